load_store_unit: RTL and testbench

Multi-cycle load/store unit between the single-cycle RISC-V core's datapath (`ALUResult` address, rs2 store data, `funct3`) and a word-wide data memory with variable latency and a req/ack handshake. It implements lb/lbu/lh/lhu/lw/sb/sh/sw:
- byte-lane steering and byte enables on stores;
- sign/zero extension on loads;
- misalignment and bus-timeout detection.

It stalls the core until each access completes.

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle RISC-V load/store unit: lane steering, load extension,
// misalignment and bus-timeout detection over a req/ack word memory.
module load_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignedErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] TO     = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        bus_q, bus_d;

    logic        access;
    logic        bad;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] sel;
    logic [31:0] load_ext;

    assign access = MemRead | MemWrite;

    always_comb begin
        bad = 1'b0;
        if (MemWrite)
            bad = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
        else
            bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        if (funct3[1:0] == 2'b01 && Addr[0])
            bad = 1'b1;
        if (funct3 == 3'b010 && Addr[1:0] != 2'b00)
            bad = 1'b1;
    end

    // Store data is replicated across lanes so memory only needs byte enables.
    always_comb begin
        be_new    = 4'b0000;
        wdata_new = 32'h0;
        if (MemWrite) begin
            unique case (funct3[1:0])
                2'b00: begin
                    wdata_new = {4{WriteData[7:0]}};
                    be_new    = 4'b0001 << Addr[1:0];
                end
                2'b01: begin
                    wdata_new = {2{WriteData[15:0]}};
                    be_new    = Addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_new = WriteData;
                    be_new    = 4'b1111;
                end
            endcase
        end
    end

    assign sel = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        unique case (f3_q)
            3'b000:  load_ext = {{24{sel[7]}}, sel[7:0]};
            3'b100:  load_ext = {24'h0, sel[7:0]};
            3'b001:  load_ext = {{16{sel[15]}}, sel[15:0]};
            3'b101:  load_ext = {16'h0, sel[15:0]};
            default: load_ext = sel;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        bus_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (access && bad) begin
                    state_d = S_DONE;
                    mis_d   = 1'b1;
                    rdata_d = 32'h0;
                end else if (access) begin
                    state_d = S_REQ;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {Addr[31:2], 2'b00};
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    f3_d    = funct3;
                    off_d   = Addr[1:0];
                end
            end
            S_REQ: begin
                // An ack in the final counted cycle still wins over timeout.
                if (mem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    if (!we_q)
                        rdata_d = load_ext;
                end else if (cnt_q + 8'd1 == TO) begin
                    state_d = S_DONE;
                    cnt_d   = cnt_q + 8'd1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    rdata_d = 32'h0;
                    bus_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            bus_q   <= bus_d;
        end
    end

    assign Stall         = access & (state_q != S_DONE);
    assign ReadData      = rdata_q;
    assign MisalignedErr = mis_q;
    assign BusErr        = bus_q;
    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_be        = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level model
// and a per-cycle compare process.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Addr, WriteData;
    logic [31:0] ReadData;
    logic        Stall, MisalignedErr, BusErr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .Addr(Addr), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall),
        .MisalignedErr(MisalignedErr), .BusErr(BusErr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit          chk_en = 0;
    logic        exp_stall, exp_req, exp_mis, exp_bus, exp_we, exp_clr;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic [31:0] m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_bad(input bit st, input logic [2:0] f3, input logic [1:0] off);
        bit b;
        if (st) b = (f3 > 3'd2);
        else    b = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if (!b && size_of(f3) == 2 && off[0]) b = 1;
        if (!b && size_of(f3) == 4 && off != 2'b00) b = 1;
        return b;
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] r;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++)
            r[i] = (i >= int'(off)) && (i < int'(off) + sz);
        return r;
    endfunction

    function automatic logic [31:0] repl(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] v, mask;
        int sz;
        sz = size_of(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*sz)) - 32'h1);
        v = (w >> (8*int'(off))) & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One compare process: checks every cycle against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", Stall, exp_stall);
            chk("mem_req", mem_req, exp_req);
            chk("mis_err", MisalignedErr, exp_mis);
            chk("bus_err", BusErr, exp_bus);
            chk("read_data", ReadData, m_rd);
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", mem_we, exp_we);
                chk("mem_be", mem_be, exp_be);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (exp_clr) begin
                chk("done_be", mem_be, 4'b0000);
                chk("done_we", mem_we, 1'b0);
            end
        end
    end

    // lat = REQ cycle carrying the ack (0 = never ack)
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int lat,
                         output logic [31:0] o_rd, output logic [3:0] o_be,
                         output logic [31:0] o_wd, output int o_stall, output int o_req);
        int n;
        bit ok;
        o_be = 4'h0; o_wd = 32'h0; o_stall = 0; o_req = 0;
        MemWrite = st; MemRead = !st; funct3 = f3; Addr = a; WriteData = wd;
        exp_stall = 1; exp_req = 0; exp_mis = 0; exp_bus = 0; exp_clr = 0;
        @(negedge clk); o_stall += int'(Stall); o_req += int'(mem_req);
        @(posedge clk); #1;
        if (is_bad(st, f3, a[1:0])) begin
            m_rd = 32'h0; exp_stall = 0; exp_mis = 1;
        end else begin
            ok = (lat >= 1 && lat <= TO);
            n = ok ? lat : TO;
            exp_req = 1; exp_we = st; exp_addr = {a[31:2], 2'b00};
            exp_be = st ? lanes(f3, a[1:0]) : 4'b0000;
            exp_wd = repl(f3, wd);
            for (int k = 1; k <= n; k++) begin
                mem_ack = (k == lat); mem_rdata = rd;
                @(negedge clk);
                o_stall += int'(Stall); o_req += int'(mem_req);
                o_be = mem_be; o_wd = mem_wdata;
                @(posedge clk); #1;
                mem_ack = 0;
            end
            exp_req = 0; exp_stall = 0;
            if (!ok) begin
                m_rd = 32'h0; exp_bus = 1;
            end else begin
                exp_clr = 1;
                if (!st) m_rd = load_val(f3, a[1:0], rd);
            end
        end
        @(negedge clk); o_stall += int'(Stall); o_req += int'(mem_req); o_rd = ReadData;
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0;
        exp_stall = 0; exp_req = 0; exp_mis = 0; exp_bus = 0; exp_clr = 0;
    endtask

    logic [31:0] rd_v, wd_v;
    logic [3:0]  be_v;
    int          ns, nr;
    localparam logic [31:0] PAT = 32'h80FF7F01;

    initial begin
        reset = 1; MemRead = 0; MemWrite = 0; funct3 = 0; Addr = 0; WriteData = 0;
        mem_ack = 0; mem_rdata = 0; m_rd = 0;
        exp_stall = 0; exp_req = 0; exp_mis = 0; exp_bus = 0; exp_we = 0; exp_clr = 0;
        exp_addr = 0; exp_wd = 0; exp_be = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", mem_be, 4'h0);
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_errs", {MisalignedErr, BusErr, Stall}, 3'b000);
        @(posedge clk); #1;
        reset = 0; chk_en = 1;

        do_op(1, 3'b010, 32'h64, 32'd25, 32'h0, 1, rd_v, be_v, wd_v, ns, nr);
        chk("sw_be", be_v, 4'b1111);
        chk("sw_wd", wd_v, 32'h19);
        chk("sw_stall", ns, 2);
        do_op(1, 3'b000, 32'h103, 32'hAB, 32'h0, 2, rd_v, be_v, wd_v, ns, nr);
        chk("sb_be", be_v, 4'b1000);
        chk("sb_wd", wd_v, 32'hABABABAB);
        chk("sb_stall", ns, 3);
        do_op(1, 3'b001, 32'h102, 32'h1234, 32'h0, 1, rd_v, be_v, wd_v, ns, nr);
        chk("sh_be", be_v, 4'b1100);
        chk("sh_wd", wd_v, 32'h12341234);
        do_op(0, 3'b000, 32'h203, 32'h0, PAT, 1, rd_v, be_v, wd_v, ns, nr);
        chk("lb3", rd_v, 32'hFFFFFF80);
        do_op(0, 3'b100, 32'h203, 32'h0, PAT, 3, rd_v, be_v, wd_v, ns, nr);
        chk("lbu3", rd_v, 32'h00000080);
        chk("lbu_stall", ns, 4);
        do_op(0, 3'b001, 32'h202, 32'h0, PAT, 1, rd_v, be_v, wd_v, ns, nr);
        chk("lh2", rd_v, 32'hFFFF80FF);
        do_op(0, 3'b101, 32'h202, 32'h0, PAT, 2, rd_v, be_v, wd_v, ns, nr);
        chk("lhu2", rd_v, 32'h000080FF);
        do_op(0, 3'b010, 32'h200, 32'h0, PAT, 1, rd_v, be_v, wd_v, ns, nr);
        chk("lw0", rd_v, 32'h80FF7F01);
        do_op(1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1, rd_v, be_v, wd_v, ns, nr);
        chk("st_keeps_rd", rd_v, 32'h80FF7F01);
        do_op(0, 3'b000, 32'h201, 32'h0, 32'h00007F00, 1, rd_v, be_v, wd_v, ns, nr);
        chk("lb1_pos", rd_v, 32'h0000007F);

        do_op(0, 3'b010, 32'h66, 32'h0, PAT, 1, rd_v, be_v, wd_v, ns, nr);
        chk("mis_lw_rd", rd_v, 32'h0);
        chk("mis_lw_stall", ns, 1);
        chk("mis_lw_req", nr, 0);
        do_op(1, 3'b001, 32'h101, 32'h5555, 32'h0, 1, rd_v, be_v, wd_v, ns, nr);
        chk("mis_sh_stall", ns, 1);
        chk("mis_sh_req", nr, 0);
        do_op(0, 3'b011, 32'h0, 32'h0, PAT, 1, rd_v, be_v, wd_v, ns, nr);
        do_op(1, 3'b100, 32'h0, 32'h1, 32'h0, 1, rd_v, be_v, wd_v, ns, nr);

        do_op(0, 3'b010, 32'h404, 32'h0, 32'h12345678, 1, rd_v, be_v, wd_v, ns, nr);
        do_op(0, 3'b010, 32'h400, 32'h0, PAT, 0, rd_v, be_v, wd_v, ns, nr);
        chk("to_req_cycles", nr, 4);
        chk("to_rd", rd_v, 32'h0);
        chk("to_stall", ns, 5);
        do_op(0, 3'b010, 32'h404, 32'h0, 32'h12345678, 4, rd_v, be_v, wd_v, ns, nr);
        chk("ack_at_to_rd", rd_v, 32'h12345678);
        chk("ack_at_to_req", nr, 4);
        do_op(1, 3'b000, 32'h10, 32'h77, 32'h0, 0, rd_v, be_v, wd_v, ns, nr);

        do_op(0, 3'b010, 32'h500, 32'h0, 32'hDEADBEEF, 1, rd_v, be_v, wd_v, ns, nr);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 0;
        MemRead = 1; funct3 = 3'b010; Addr = 32'h600;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_req", mem_req, 1'b1);
        reset = 1; MemRead = 0; #1;
        chk("rst_mid_req", mem_req, 1'b0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        chk("rst_mid_rd", ReadData, 32'h0);
        chk("rst_mid_stall", Stall, 1'b0);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'h13572468;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("late_ack_req", mem_req, 1'b0);
        chk("late_ack_rd", ReadData, 32'h0);
        chk("late_ack_err", {MisalignedErr, BusErr}, 2'b00);
        m_rd = 0; chk_en = 1;
        do_op(0, 3'b001, 32'h702, 32'h0, PAT, 1, rd_v, be_v, wd_v, ns, nr);
        chk("post_rst_lh", rd_v, 32'hFFFF80FF);
        chk("post_rst_stall", ns, 2);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
